// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
package gate_test_pkg;

  // Sequencer states: wait for a run, hold a vector, sample it, report.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // A 2-input gate has exactly four input vectors.
  localparam int NUM_VEC = 4;

  // Expected truth tables: bit i is the gate output for {a,b} = i.
  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VEC-1:0] TT_XNOR = 4'b1001;

  // Next vector index, wrapping within the four vectors.
  function automatic logic [1:0] next_vec(input logic [1:0] idx);
    return 2'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle-interval counter: cleared when a vector is applied, counts while
// enabled, and flags the last settle cycle so the FSM can move to SAMPLE.
module gate_settle_timer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority so a fresh vector always starts its settle at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: the SETTLE cycle in which the next state becomes SAMPLE.
  assign tc = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Exhaustive self-test sequencer for one external 2-input gate. Applies the
// vectors 00,01,10,11, holds each for SETTLE_CYCLES, samples the gate output
// and compares it against a truth table latched at start.
module gate_selftest_ctrl
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,  // legal 1..15
  parameter int CNT_W         = 4   // 2**CNT_W must exceed SETTLE_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_VEC-1:0] exp_tt,
  output logic               gate_a,
  output logic               gate_b,
  input  logic               gate_y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] fail_mask,
  output logic [1:0]         vec_idx
);

  state_e             state_q, state_d;
  logic [1:0]         vec_idx_q, vec_idx_d;
  logic [1:0]         gate_ab_q, gate_ab_d;
  logic [NUM_VEC-1:0] exp_tt_q, exp_tt_d;
  logic [NUM_VEC-1:0] fail_mask_q, fail_mask_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               tmr_clear;
  logic               tmr_en;
  logic               tmr_tc;
  logic [NUM_VEC-1:0] fail_set;
  logic [NUM_VEC-1:0] fail_mask_upd;
  logic               last_vec;

  gate_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(tmr_clear),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

  // Per-vector mismatch: only the vector being sampled can flag. Case
  // inequality makes an X or Z on gate_y count as a failure.
  for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_cmp
    assign fail_set[gi] = (vec_idx_q == 2'(gi)) && (gate_y !== exp_tt_q[gi]);
  end

  assign fail_mask_upd = fail_mask_q | fail_set;
  assign last_vec      = (vec_idx_q == 2'(NUM_VEC - 1));

  // Next-state and next-output logic. busy/done are computed from the state
  // being entered so their registered copies line up with that state.
  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    gate_ab_d   = gate_ab_q;
    exp_tt_d    = exp_tt_q;
    fail_mask_d = fail_mask_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    tmr_clear   = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        gate_ab_d = 2'b00;
        if (start) begin
          exp_tt_d    = exp_tt;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          vec_idx_d   = 2'd0;
          tmr_clear   = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        busy_d = 1'b1;
        tmr_en = 1'b1;
        if (tmr_tc) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        fail_mask_d = fail_mask_upd;
        if (last_vec) begin
          // Result includes a mismatch captured in this final sample.
          gate_ab_d = 2'b00;
          pass_d    = (fail_mask_upd == '0);
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          vec_idx_d = next_vec(vec_idx_q);
          gate_ab_d = next_vec(vec_idx_q);
          tmr_clear = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SETTLE;
        end
      end

      ST_DONE: begin
        // start is deliberately ignored here; a held start is taken in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset aborts a run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_idx_q   <= 2'd0;
      gate_ab_q   <= 2'b00;
      exp_tt_q    <= '0;
      fail_mask_q <= '0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      gate_ab_q   <= gate_ab_d;
      exp_tt_q    <= exp_tt_d;
      fail_mask_q <= fail_mask_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Gate drives come straight from flops, so they only move on clock edges.
  assign gate_a    = gate_ab_q[1];
  assign gate_b    = gate_ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Self-checking bench for gate_selftest_ctrl. A behavioural gate model drives
// gate_y from a 4-bit table; expected results come from the rule
// "fail bit i = gate output for vector i differs from expected bit i".
// Observation index t counts edges after the accepting edge: the value seen
// #1 after edge t is what the specification calls cycle t+1.
module tb_gate_selftest_ctrl;
  import gate_test_pkg::*;

  localparam int S0 = 2;
  localparam int P0 = S0 + 1;
  localparam int L0 = 4 * P0;      // t of done for the default DUT (cycle 13)
  localparam int S1 = 1;
  localparam int L1 = 4 * (S1 + 1); // t of done for the fast DUT (cycle 9)
  localparam int TRACE = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, start_1;
  logic [3:0] exp_tt, exp_tt_1;
  logic [3:0] gate_tt, gate_tt_1;
  logic       gate_a, gate_b, gate_y, busy, done, pass;
  logic [3:0] fail_mask;
  logic [1:0] vec_idx;
  logic       gate_a_1, gate_b_1, gate_y_1, busy_1, done_1, pass_1;
  logic [3:0] fail_mask_1;
  logic [1:0] vec_idx_1;

  int checks = 0;
  int errors = 0;

  // Behavioural gates: output is the table entry selected by {a,b}.
  assign gate_y   = gate_tt[{gate_a, gate_b}];
  assign gate_y_1 = gate_tt_1[{gate_a_1, gate_b_1}];

  gate_selftest_ctrl #(.SETTLE_CYCLES(S0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_tt(exp_tt),
    .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y), .busy(busy),
    .done(done), .pass(pass), .fail_mask(fail_mask), .vec_idx(vec_idx)
  );

  gate_selftest_ctrl #(.SETTLE_CYCLES(S1), .CNT_W(4)) dut_1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .exp_tt(exp_tt_1),
    .gate_a(gate_a_1), .gate_b(gate_b_1), .gate_y(gate_y_1), .busy(busy_1),
    .done(done_1), .pass(pass_1), .fail_mask(fail_mask_1), .vec_idx(vec_idx_1)
  );

  // Observation trace of one run on the default DUT.
  logic [1:0] tr_ab   [TRACE];
  logic [1:0] tr_vec  [TRACE];
  logic       tr_busy [TRACE];
  logic       tr_done [TRACE];
  logic       tr_pass [TRACE];
  logic [3:0] tr_mask [TRACE];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: a vector fails when the gate output is not identical
  // to the expected bit (an unknown output never matches).
  function automatic logic [3:0] model_mask(input logic [3:0] actual,
                                            input logic [3:0] expv);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (actual[i] !== expv[i]);
    return m;
  endfunction

  function automatic int first_done();
    for (int t = 0; t < TRACE; t++) if (tr_done[t]) return t;
    return -1;
  endfunction

  function automatic int done_count();
    int n = 0;
    for (int t = 0; t < TRACE; t++) if (tr_done[t]) n++;
    return n;
  endfunction

  // Starts one run with a single-cycle start and records TRACE observations.
  // exp_tt is scrambled after acceptance; the run must use the latched value.
  task automatic run_main(input logic [3:0] expv, input logic [3:0] gtt);
    gate_tt = gtt;
    exp_tt  = expv;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    exp_tt = 4'($urandom);
    for (int t = 0; t < TRACE; t++) begin
      tr_ab[t]   = {gate_a, gate_b};
      tr_vec[t]  = vec_idx;
      tr_busy[t] = busy;
      tr_done[t] = done;
      tr_pass[t] = pass;
      tr_mask[t] = fail_mask;
      if (t < TRACE - 1) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_1 = 1'b0;
    exp_tt = TT_NAND; exp_tt_1 = TT_NAND;
    gate_tt = TT_NAND; gate_tt_1 = TT_NAND;
    tick(); tick();
    checks++;
    if ({gate_a, gate_b, busy, done, pass, fail_mask, vec_idx} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0", {gate_a, gate_b, busy, done, pass, fail_mask, vec_idx});
    end
    checks++;
    if ({gate_a_1, gate_b_1, busy_1, done_1, pass_1, fail_mask_1, vec_idx_1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs_1 got=%b want=0", {gate_a_1, gate_b_1, busy_1, done_1, pass_1, fail_mask_1, vec_idx_1});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset busy/done got=%b want=00", {busy, done});
    end
  endtask

  task automatic test_nand_pass();
    run_main(TT_NAND, TT_NAND);
    for (int t = 0; t < TRACE; t++) begin
      logic [1:0] want_ab;
      want_ab = (t < L0) ? 2'(t / P0) : 2'b00;
      checks++;
      if (tr_ab[t] !== want_ab) begin
        errors++;
        $display("FAIL nand_ab t=%0d got=%b want=%b", t, tr_ab[t], want_ab);
      end
      checks++;
      if (tr_busy[t] !== (t < L0)) begin
        errors++;
        $display("FAIL nand_busy t=%0d got=%b want=%b", t, tr_busy[t], (t < L0));
      end
      checks++;
      if (tr_done[t] !== (t == L0)) begin
        errors++;
        $display("FAIL nand_done t=%0d got=%b want=%b", t, tr_done[t], (t == L0));
      end
      if (t < L0) begin
        checks++;
        if (tr_vec[t] !== want_ab) begin
          errors++;
          $display("FAIL nand_vec t=%0d got=%0d want=%0d", t, tr_vec[t], want_ab);
        end
      end
    end
    checks++;
    if (tr_pass[L0] !== 1'b1) begin
      errors++;
      $display("FAIL nand_pass got=%b want=1", tr_pass[L0]);
    end
    checks++;
    if (tr_mask[L0] !== 4'b0000) begin
      errors++;
      $display("FAIL nand_mask got=%b want=0000", tr_mask[L0]);
    end
  endtask

  task automatic test_and_mismatch();
    run_main(TT_AND, TT_NAND);
    checks++;
    if (first_done() != L0) begin
      errors++;
      $display("FAIL and_done_time got=%0d want=%0d", first_done(), L0);
    end
    checks++;
    if (tr_pass[L0] !== 1'b0 || tr_mask[L0] !== 4'b1111) begin
      errors++;
      $display("FAIL and_result got pass=%b mask=%b want pass=0 mask=1111", tr_pass[L0], tr_mask[L0]);
    end
    // Result must hold after done until the next accepted start.
    checks++;
    if (tr_mask[TRACE-1] !== 4'b1111 || tr_pass[TRACE-1] !== 1'b0) begin
      errors++;
      $display("FAIL and_hold got pass=%b mask=%b want pass=0 mask=1111", tr_pass[TRACE-1], tr_mask[TRACE-1]);
    end
  endtask

  task automatic test_stuck_and_x();
    logic [3:0] want;
    run_main(TT_NAND, 4'b1111);
    checks++;
    if (tr_mask[L0] !== 4'b1000 || tr_pass[L0] !== 1'b0) begin
      errors++;
      $display("FAIL stuck1 got pass=%b mask=%b want pass=0 mask=1000", tr_pass[L0], tr_mask[L0]);
    end
    // NAND with an unknown output on vector 01 only.
    gate_tt = 4'b01x1;
    want = model_mask(gate_tt, TT_NAND);
    run_main(TT_NAND, 4'b01x1);
    checks++;
    if (tr_mask[L0] !== want || tr_pass[L0] !== (want == 4'b0000)) begin
      errors++;
      $display("FAIL x_on_01 got pass=%b mask=%b want pass=%b mask=%b", tr_pass[L0], tr_mask[L0], (want == 4'b0000), want);
    end
  endtask

  task automatic test_restart_ignored();
    int dn_t = -1;
    int dn_n = 0;
    logic p_at = 1'b0;
    logic [3:0] m_at = 4'hf;
    gate_tt = TT_NAND;
    exp_tt  = TT_NAND;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < TRACE; t++) begin
      if (done) begin
        dn_n++;
        if (dn_t < 0) dn_t = t;
      end
      if (t == L0) begin
        p_at = pass;
        m_at = fail_mask;
      end
      if (t == 3) exp_tt = 4'b0000;  // present during cycle 4
      if (t == 4) start = 1'b1;      // present during cycle 5
      if (t == 5) start = 1'b0;
      tick();
    end
    checks++;
    if (dn_t != L0 || dn_n != 1) begin
      errors++;
      $display("FAIL restart_done got t=%0d count=%0d want t=%0d count=1", dn_t, dn_n, L0);
    end
    checks++;
    if (p_at !== 1'b1 || m_at !== 4'b0000) begin
      errors++;
      $display("FAIL restart_result got pass=%b mask=%b want pass=1 mask=0000", p_at, m_at);
    end
  endtask

  task automatic test_midrun_reset();
    gate_tt = TT_NAND;
    exp_tt  = TT_AND;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();            // now in cycle 7: vector 2 applied, mask nonzero
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, gate_a, gate_b, fail_mask, vec_idx, done} !== 10'd0) begin
      errors++;
      $display("FAIL midrun_abort got=%b want=0", {busy, gate_a, gate_b, fail_mask, vec_idx, done});
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrun_held c=%0d got done=%b busy=%b want 0 0", c, done, busy);
      end
    end
    rst_n = 1'b1;
    run_main(TT_NAND, TT_NAND);
    checks++;
    if (first_done() != L0 || done_count() != 1) begin
      errors++;
      $display("FAIL after_reset_done got t=%0d count=%0d want t=%0d count=1", first_done(), done_count(), L0);
    end
    checks++;
    if (tr_pass[L0] !== 1'b1 || tr_mask[L0] !== 4'b0000) begin
      errors++;
      $display("FAIL after_reset_result got pass=%b mask=%b want pass=1 mask=0000", tr_pass[L0], tr_mask[L0]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      logic [3:0] gtt, expv, want;
      gtt  = 4'($urandom);
      expv = 4'($urandom);
      if ($urandom_range(0, 3) == 0) gtt[$urandom_range(0, 3)] = 1'bx;
      want = model_mask(gtt, expv);
      run_main(expv, gtt);
      for (int t = 0; t <= L0 + 1; t++) begin
        logic [1:0] want_ab;
        want_ab = (t < L0) ? 2'(t / P0) : 2'b00;
        checks++;
        if (tr_ab[t] !== want_ab || tr_busy[t] !== (t < L0) || tr_done[t] !== (t == L0)) begin
          errors++;
          $display("FAIL rand%0d_trace t=%0d got ab=%b busy=%b done=%b want ab=%b busy=%b done=%b",
                   r, t, tr_ab[t], tr_busy[t], tr_done[t], want_ab, (t < L0), (t == L0));
        end
      end
      checks++;
      if (tr_mask[L0] !== want || tr_pass[L0] !== (want == 4'b0000)) begin
        errors++;
        $display("FAIL rand%0d_result gate=%b exp=%b got pass=%b mask=%b want pass=%b mask=%b",
                 r, gtt, expv, tr_pass[L0], tr_mask[L0], (want == 4'b0000), want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dq[$];
    gate_tt_1 = TT_NAND;
    exp_tt_1  = TT_AND;
    start_1   = 1'b1;
    tick();
    exp_tt_1 = TT_NAND;           // latched only by the second run
    for (int t = 0; t < 22; t++) begin
      if (done_1) dq.push_back(t);
      if (t == L1) begin
        checks++;
        if (pass_1 !== 1'b0 || fail_mask_1 !== 4'b1111) begin
          errors++;
          $display("FAIL b2b_run1 got pass=%b mask=%b want pass=0 mask=1111", pass_1, fail_mask_1);
        end
      end
      if (t == L1 + 1) begin
        checks++;
        if (busy_1 !== 1'b0 || fail_mask_1 !== 4'b1111) begin
          errors++;
          $display("FAIL b2b_idle_gap got busy=%b mask=%b want busy=0 mask=1111", busy_1, fail_mask_1);
        end
      end
      if (t == L1 + 2) begin
        checks++;
        if (busy_1 !== 1'b1 || fail_mask_1 !== 4'b0000) begin
          errors++;
          $display("FAIL b2b_restart got busy=%b mask=%b want busy=1 mask=0000", busy_1, fail_mask_1);
        end
      end
      if (t == 2 * L1 + 2) begin
        checks++;
        if (pass_1 !== 1'b1 || fail_mask_1 !== 4'b0000) begin
          errors++;
          $display("FAIL b2b_run2 got pass=%b mask=%b want pass=1 mask=0000", pass_1, fail_mask_1);
        end
        start_1 = 1'b0;
      end
      tick();
    end
    checks++;
    if (dq.size() != 2 || dq[0] != L1 || dq[1] != 2 * L1 + 2) begin
      errors++;
      $display("FAIL b2b_done_times got count=%0d first=%0d second=%0d want 2 %0d %0d",
               dq.size(), (dq.size() > 0) ? dq[0] : -1, (dq.size() > 1) ? dq[1] : -1, L1, 2 * L1 + 2);
    end
  endtask

  initial begin
    test_reset();
    test_nand_pass();
    test_and_mismatch();
    test_stuck_and_x();
    test_restart_ignored();
    test_midrun_reset();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on simulated time in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
